// File: rtl/adc_capture_ctrl.sv
// adc_capture_ctrl: trigger-qualified capture of downsampled DSP samples into a
// CPU-readable dual-port RAM with optional decimation.
`default_nettype none

module adc_capture_ctrl #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 10
) (
  input  logic                     sys_clk,
  input  logic                     rst_n,
  input  logic signed [DATA_W-1:0] sample_in,
  input  logic                     sample_valid,
  input  logic                     cfg_arm,
  input  logic                     cfg_abort,
  input  logic [1:0]               cfg_trig_mode,
  input  logic signed [DATA_W-1:0] cfg_threshold,
  input  logic [ADDR_W:0]          cfg_length,
  input  logic [7:0]               cfg_decim,
  input  logic [ADDR_W-1:0]        rd_addr,
  output logic [DATA_W-1:0]        rd_data,
  output logic [1:0]               state,
  output logic [ADDR_W:0]          capture_count,
  output logic                     done_irq
);

  localparam int             DEPTH_N = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] DEPTH  = {1'b1, {ADDR_W{1'b0}}};

  localparam logic [1:0] MODE_IMM  = 2'd0;
  localparam logic [1:0] MODE_RISE = 2'd1;
  localparam logic [1:0] MODE_FALL = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ARMED   = 2'd1,
    S_CAPTURE = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  state_t                     state_q, state_d;
  logic [ADDR_W:0]            count_q, count_d, count_inc;
  logic signed [DATA_W-1:0]   prev_q, prev_d;
  logic                       prev_valid_q, prev_valid_d;
  logic [7:0]                 decim_cnt_q, decim_cnt_d;
  logic                       done_d;
  logic                       cfg_load;

  logic [1:0]                 mode_q, mode_in;
  logic signed [DATA_W-1:0]   thr_q;
  logic [ADDR_W:0]            len_q, len_in;
  logic [7:0]                 decim_q;

  logic                       trig;
  logic                       we;
  logic [ADDR_W-1:0]          waddr;

  logic [DATA_W-1:0]          mem [0:DEPTH_N-1];

  // Reserved mode folds into immediate; out-of-range lengths mean full depth.
  assign mode_in   = (cfg_trig_mode == 2'd3) ? MODE_IMM : cfg_trig_mode;
  assign len_in    = ((cfg_length == '0) || (cfg_length > DEPTH)) ? DEPTH : cfg_length;
  assign count_inc = count_q + 1'b1;

  always_comb begin
    trig = 1'b1;
    case (mode_q)
      MODE_RISE: trig = prev_valid_q && (prev_q < thr_q) && (sample_in >= thr_q);
      MODE_FALL: trig = prev_valid_q && (prev_q > thr_q) && (sample_in <= thr_q);
      default:   trig = 1'b1;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    prev_d       = prev_q;
    prev_valid_d = prev_valid_q;
    decim_cnt_d  = decim_cnt_q;
    done_d       = 1'b0;
    cfg_load     = 1'b0;
    we           = 1'b0;
    waddr        = count_q[ADDR_W-1:0];

    case (state_q)
      S_IDLE, S_DONE: begin
        if (cfg_arm && !cfg_abort) begin
          state_d      = S_ARMED;
          count_d      = '0;
          prev_valid_d = 1'b0;
          cfg_load     = 1'b1;
        end
      end

      S_ARMED: begin
        if (sample_valid) begin
          prev_d       = sample_in;
          prev_valid_d = 1'b1;
          if (trig) begin
            we          = 1'b1;
            waddr       = '0;
            count_d     = {{ADDR_W{1'b0}}, 1'b1};
            decim_cnt_d = '0;
            if (len_q == {{ADDR_W{1'b0}}, 1'b1}) begin
              state_d = S_DONE;
              done_d  = 1'b1;
            end else begin
              state_d = S_CAPTURE;
            end
          end
        end
      end

      S_CAPTURE: begin
        if (sample_valid) begin
          if (decim_cnt_q == decim_q) begin
            decim_cnt_d = '0;
            we          = 1'b1;
            count_d     = count_inc;
            if (count_inc == len_q) begin
              state_d = S_DONE;
              done_d  = 1'b1;
            end
          end else begin
            decim_cnt_d = decim_cnt_q + 8'd1;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase

    // Abort overrides the state change and interrupt, but not the data side.
    if (cfg_abort) begin
      state_d = S_IDLE;
      done_d  = 1'b0;
    end
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      count_q      <= '0;
      prev_q       <= '0;
      prev_valid_q <= 1'b0;
      decim_cnt_q  <= '0;
      done_irq     <= 1'b0;
      mode_q       <= MODE_IMM;
      thr_q        <= '0;
      len_q        <= DEPTH;
      decim_q      <= '0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      prev_q       <= prev_d;
      prev_valid_q <= prev_valid_d;
      decim_cnt_q  <= decim_cnt_d;
      done_irq     <= done_d;
      if (cfg_load) begin
        mode_q  <= mode_in;
        thr_q   <= cfg_threshold;
        len_q   <= len_in;
        decim_q <= cfg_decim;
      end
    end
  end

  // Contents are deliberately not reset so the array maps onto block RAM.
  always_ff @(posedge sys_clk) begin
    if (we) begin
      mem[waddr] <= sample_in;
    end
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data <= '0;
    end else begin
      rd_data <= mem[rd_addr];
    end
  end

  assign state         = state_q;
  assign capture_count = count_q;

endmodule

`default_nettype wire

// File: tb/tb_adc_capture_ctrl.sv
// tb_adc_capture_ctrl: randomized and directed capture scenarios checked against
// a queue-based model of trigger search and decimated storage.
`default_nettype none

module tb_adc_capture_ctrl;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 4;
  localparam int DEPTH  = 16;

  logic                     sys_clk = 1'b0;
  logic                     rst_n;
  logic signed [DATA_W-1:0] sample_in;
  logic                     sample_valid;
  logic                     cfg_arm;
  logic                     cfg_abort;
  logic [1:0]               cfg_trig_mode;
  logic signed [DATA_W-1:0] cfg_threshold;
  logic [ADDR_W:0]          cfg_length;
  logic [7:0]               cfg_decim;
  logic [ADDR_W-1:0]        rd_addr;
  logic [DATA_W-1:0]        rd_data;
  logic [1:0]               state;
  logic [ADDR_W:0]          capture_count;
  logic                     done_irq;

  int n_tests = 0;
  int n_fail  = 0;
  int irq_cnt = 0;

  adc_capture_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .sys_clk       (sys_clk),
    .rst_n         (rst_n),
    .sample_in     (sample_in),
    .sample_valid  (sample_valid),
    .cfg_arm       (cfg_arm),
    .cfg_abort     (cfg_abort),
    .cfg_trig_mode (cfg_trig_mode),
    .cfg_threshold (cfg_threshold),
    .cfg_length    (cfg_length),
    .cfg_decim     (cfg_decim),
    .rd_addr       (rd_addr),
    .rd_data       (rd_data),
    .state         (state),
    .capture_count (capture_count),
    .done_irq      (done_irq)
  );

  always #5 sys_clk = ~sys_clk;

  always @(negedge sys_clk) if (done_irq) irq_cnt++;

  task automatic check(input string tag, input longint got, input longint exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic junk_cfg();
    cfg_trig_mode = 2'($urandom);
    cfg_threshold = 16'($urandom);
    cfg_length    = 5'($urandom);
    cfg_decim     = 8'($urandom);
  endtask

  task automatic arm(input int mode, input int thr, input int len, input int decim);
    @(negedge sys_clk);
    sample_valid  = 1'b0;
    cfg_trig_mode = 2'(mode);
    cfg_threshold = 16'(thr);
    cfg_length    = 5'(len);
    cfg_decim     = 8'(decim);
    cfg_arm       = 1'b1;
    irq_cnt       = 0;
    @(negedge sys_clk);
    cfg_arm = 1'b0;
    junk_cfg();
    check("arm_state", state, 1);
    check("arm_count", capture_count, 0);
  endtask

  task automatic push(input int v, input int gap);
    int g;
    g = (gap < 0) ? int'($urandom_range(0, 3)) : gap;
    @(negedge sys_clk);
    sample_valid = 1'b1;
    sample_in    = 16'(v);
    repeat (g) begin
      @(negedge sys_clk);
      sample_valid = 1'b0;
      sample_in    = 16'($urandom);
    end
  endtask

  task automatic read_chk(input int addr, input int exp);
    @(negedge sys_clk);
    sample_valid = 1'b0;
    rd_addr      = 4'(addr);
    @(negedge sys_clk);
    check($sformatf("ram[%0d]", addr), longint'($signed(rd_data)), exp);
  endtask

  function automatic int gen(input int kind, input int i, input int base, input int step);
    real ph;
    case (kind)
      0: return base + step * i;
      1: begin
        ph = 2.0 * 3.14159265 * real'(i + base) / 24.0;
        return int'(1000.0 * $sin(ph));
      end
      2: return int'($urandom_range(0, 2 * base)) - base;
      default: return base + step * ((i > 8) ? (i - 8) : (8 - i));
    endcase
  endfunction

  // Arms, feeds n valid samples, then checks the outcome against the model.
  task automatic run_cap(input int mode, input int thr, input int len, input int decim,
                         input int n, input int kind, input int base, input int step,
                         input int gap, input bit mid_arm);
    int q[$];
    int exp_q[$];
    int trig, leff, emode, v, exp_state;
    arm(mode, thr, len, decim);
    for (int i = 0; i < n; i++) begin
      if (mid_arm && i == n / 2) begin
        @(negedge sys_clk);
        sample_valid = 1'b0;
        cfg_trig_mode = 2'd1; cfg_threshold = 16'sd30000; cfg_length = 5'd2; cfg_decim = 8'd0;
        cfg_arm = 1'b1;
        @(negedge sys_clk);
        cfg_arm = 1'b0;
        junk_cfg();
      end
      v = gen(kind, i, base, step);
      q.push_back(v);
      push(v, gap);
    end
    @(negedge sys_clk);
    sample_valid = 1'b0;
    repeat (3) @(negedge sys_clk);

    leff  = (len == 0 || len > DEPTH) ? DEPTH : len;
    emode = (mode == 3) ? 0 : mode;
    trig  = -1;
    for (int i = 0; i < q.size() && trig < 0; i++) begin
      if (emode == 0) trig = i;
      else if (i > 0 && emode == 1 && q[i-1] < thr && q[i] >= thr) trig = i;
      else if (i > 0 && emode == 2 && q[i-1] > thr && q[i] <= thr) trig = i;
    end
    if (trig >= 0)
      for (int idx = trig; idx < q.size() && exp_q.size() < leff; idx += decim + 1)
        exp_q.push_back(q[idx]);
    exp_state = (trig < 0) ? 1 : ((exp_q.size() == leff) ? 3 : 2);

    check("state", state, exp_state);
    check("count", capture_count, exp_q.size());
    check("irq_pulses", irq_cnt, (exp_state == 3) ? 1 : 0);
    foreach (exp_q[k]) read_chk(k, exp_q[k]);
  endtask

  initial begin
    rst_n = 1'b0;
    sample_in = '0; sample_valid = 1'b0; cfg_arm = 1'b0; cfg_abort = 1'b0;
    cfg_trig_mode = '0; cfg_threshold = '0; cfg_length = '0; cfg_decim = '0; rd_addr = '0;
    #12;
    check("rst_state", state, 0);
    check("rst_count", capture_count, 0);
    check("rst_irq", done_irq, 0);
    check("rst_rd", rd_data, 0);
    @(negedge sys_clk);
    rst_n = 1'b1;

    // Immediate ramp, valid every 4th cycle; extra samples must not be stored.
    run_cap(0, 0, 8, 0, 11, 0, 0, 1, 3, 1'b0);
    // Rising crossing on a ramp from -50.
    run_cap(1, 100, 4, 0, 20, 0, -50, 10, -1, 1'b0);
    // Rising: first sample above threshold, dips, then rises through 100.
    run_cap(1, 100, 3, 0, 16, 3, 70, 10, -1, 1'b0);
    // Falling on a sine starting at its trough (rising pass first).
    run_cap(2, -200, 5, 0, 30, 1, 18, 0, -1, 1'b0);
    // Decimation 2, with an arm pulse mid-capture that must be ignored.
    run_cap(0, 0, 4, 2, 14, 0, 0, 1, -1, 1'b1);
    // Length 1 and reserved mode.
    run_cap(3, 0, 1, 0, 4, 0, 7, 3, -1, 1'b0);
    // Length 0 means full depth; then a re-arm out of DONE.
    run_cap(0, 0, 0, 0, 20, 0, 100, -7, 0, 1'b0);
    run_cap(0, 0, 20, 1, 40, 2, 500, 0, -1, 1'b0);

    // Abort after 3 stored samples.
    arm(0, 0, 8, 0);
    for (int i = 0; i < 3; i++) push(40 + i, 0);
    @(negedge sys_clk);
    sample_valid = 1'b0;
    cfg_abort = 1'b1;
    @(negedge sys_clk);
    cfg_abort = 1'b0;
    check("abort_state", state, 0);
    check("abort_count", capture_count, 3);
    push(99, 0);
    @(negedge sys_clk);
    sample_valid = 1'b0;
    check("abort_irq", irq_cnt, 0);
    check("abort_hold", capture_count, 3);
    // Arm and abort together from IDLE.
    cfg_arm = 1'b1; cfg_abort = 1'b1;
    @(negedge sys_clk);
    cfg_arm = 1'b0; cfg_abort = 1'b0;
    check("armabort_state", state, 0);
    check("armabort_count", capture_count, 3);

    for (int r = 0; r < 8; r++)
      run_cap(int'($urandom_range(0, 3)), int'($urandom_range(0, 100)) - 50,
              int'($urandom_range(0, 20)), int'($urandom_range(0, 3)),
              40, 2, 150, 0, -1, 1'b0);

    // Asynchronous reset mid-capture.
    arm(0, 0, 0, 0);
    for (int i = 0; i < 5; i++) push(i + 1, 0);
    @(negedge sys_clk);
    sample_valid = 1'b0;
    rd_addr = 4'd2;
    @(negedge sys_clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_state", state, 0);
    check("arst_count", capture_count, 0);
    check("arst_irq", done_irq, 0);
    check("arst_rd", rd_data, 0);
    @(negedge sys_clk);
    rst_n = 1'b1;
    #1 check("arst_rd_rel", rd_data, 0);
    @(negedge sys_clk);
    check("arst_rd_after", longint'($signed(rd_data)), 3);
    check("arst_state_after", state, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running, expected finished");
    $fatal(1);
  end

endmodule

`default_nettype wire

// File: doc/adc_capture_ctrl.md
Name: adc_capture_ctrl

Overview:
Capture sequencer for the ADC -> downsampler -> upsampler -> DAC datapath. It watches the downsampled filter output, which is qualified by the downsampler ce_out. When the configured trigger condition is met it stores a programmable number of (optionally decimated) samples into an internal RAM. The SoC CPU arms the capture and reads the RAM through CSRs; the block sits beside the DSP path and never stalls it.

Parameters:
DATA_W, 16, sample width (signed two's complement)
ADDR_W, 10, RAM address width; depth = 2**ADDR_W samples

Ports:
sys_clk  in  1  system clock; the DSP path runs on the same clock
rst_n  in  1  asynchronous active-low reset
sample_in  in  DATA_W  signed downsampled filter output
sample_valid  in  1  ce_out of the downsampler; sample_in is valid when 1
cfg_arm  in  1  single-cycle pulse: latch config, start a capture
cfg_abort  in  1  single-cycle pulse: cancel the capture
cfg_trig_mode  in  2  0 = immediate, 1 = rising crossing, 2 = falling crossing, 3 = reserved (treated as 0)
cfg_threshold  in  DATA_W  signed trigger threshold
cfg_length  in  ADDR_W+1  samples to store; 0 or > 2**ADDR_W means 2**ADDR_W
cfg_decim  in  8  store 1 of every cfg_decim+1 valid samples
rd_addr  in  ADDR_W  CPU read address
rd_data  out  DATA_W  RAM word at rd_addr, registered
state  out  2  0 = IDLE, 1 = ARMED, 2 = CAPTURE, 3 = DONE
capture_count  out  ADDR_W+1  samples stored so far
done_irq  out  1  one-cycle pulse on entry to DONE

Behaviour:
- Reset values: state = IDLE, capture_count = 0, done_irq = 0, rd_data = 0, internal prev-sample valid flag = 0, decimation counter = 0. RAM contents are not reset.
- Config is latched on cfg_arm. Changes to cfg_* afterwards have no effect until the next arm.
- State transitions:
  - IDLE/DONE + cfg_arm -> ARMED. capture_count <= 0, prev-valid <= 0.
  - ARMED:
    - Immediate mode: the first sample_valid cycle is the trigger.
    - Rising mode: trigger when prev-valid and prev < thr and cur >= thr.
    - Falling mode: trigger when prev-valid and prev > thr and cur <= thr.
    - Each valid sample updates prev and sets prev-valid. The first valid sample after arm can never trigger in crossing modes.
    - On trigger -> CAPTURE. The trigger sample is written to address 0 in the same cycle, capture_count <= 1, decimation counter <= 0.
  - CAPTURE:
    - On each sample_valid the decimation counter increments and wraps from cfg_decim to 0.
    - A sample is written at address capture_count, and capture_count increments, only on a valid cycle where the counter wraps to 0. Thus stored samples are spaced cfg_decim+1 valid samples apart, with the trigger sample first.
    - When capture_count reaches the effective length -> DONE. done_irq pulses high the cycle state becomes DONE.
    - A length of 1 goes ARMED -> DONE directly on the trigger cycle.
  - ARMED/CAPTURE + cfg_arm: ignored.
  - Any state + cfg_abort -> IDLE next cycle. capture_count holds its value, no done_irq. Abort wins over arm in the same cycle. Abort also wins over completion in the same cycle; that final write still occurs.
  - DONE holds until cfg_arm.
- Invalid cycles (sample_valid = 0) change nothing except rd_data.
- Comparisons are signed and DATA_W wide.
- RAM is simple dual-port: a write port from the FSM and a read port on rd_addr. rd_data latency is exactly 1 cycle. A read of the address being written in the same cycle returns the old data. Reads are legal in any state.
- capture_count never exceeds 2**ADDR_W. The write address is capture_count[ADDR_W-1:0], so there is no wrap within a capture.
- Asynchronous reset mid-capture forces IDLE immediately; rd_data is 0 until the first clock after release.

Test Plan:
1. Immediate mode, length 8, decim 0, sample_valid every 4th cycle with ramp 0,1,2… after arm -> RAM[0..7] = 0..7, done_irq single pulse after 8th valid, capture_count = 8, state = 3.
2. Rising mode, thr = 100, ramp -50 step 10 on valid cycles -> first stored sample = 100, next = 110; a first post-arm sample already >= 100 must not trigger.
3. Falling mode, thr = -200 signed, sine input of amplitude 1000 -> RAM[0] <= -200 and the preceding input sample > -200; verify no trigger on a rising pass.
4. Decim = 2, length 4, ramp 0.. -> RAM[0..3] = 0,3,6,9; capture_count = 4.
5. Abort in CAPTURE after 3 stored samples -> state 0 next cycle, capture_count = 3, no done_irq. Arm+abort on the same cycle from IDLE -> stays IDLE.
6. cfg_length = 0 with ADDR_W = 4 -> 16 samples stored then DONE. A second arm in DONE restarts with count 0. Reset asserted mid-capture -> state 0, outputs at reset values.
